// File: rtl/aec_stream.sv
// -----------------------------------------------------------------------------
// aec_stream
// Streaming ASCII arithmetic-expression evaluator. Single-digit operands,
// '+', '-', '*' with normal precedence, nested parentheses, terminated by '='.
// Arithmetic is modulo 2^DW. One operator is reduced per clock cycle.
//
// Parameters
//   DW    : width of operands, intermediate values and result
//   DEPTH : entries in each of the operand and operator stacks
//   HEX   : 1 -> 'a'-'f' are operands 10-15, 0 -> they are illegal characters
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   ready    : character-present strobe from the source
//   ascii_in : ASCII character, consumed on an edge where ready && accept
//   accept   : block can consume a character this cycle (state-only)
//   valid    : one-cycle pulse qualifying result/error
//   result   : expression value, 0 when error is set
//   error    : malformed expression or stack overflow
// -----------------------------------------------------------------------------
module aec_stream #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int HEX   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ready,
    input  logic [7:0]    ascii_in,
    output logic          accept,
    output logic          valid,
    output logic [DW-1:0] result,
    output logic          error
);

    localparam int PW = $clog2(DEPTH + 1);                   // stack pointer width
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;     // stack index width

    typedef enum logic [2:0] {S_IDLE, S_READ, S_REDUCE, S_FLUSH, S_DONE, S_ERR} state_e;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_LPAR, OP_RPAR} op_e;

    state_e        state_q, state_d;
    logic [PW-1:0] osp_q, osp_d;       // operand stack pointer (entries in use)
    logic [PW-1:0] psp_q, psp_d;       // operator stack pointer (entries in use)
    logic [DW-1:0] opnd_q [DEPTH];
    logic [DW-1:0] opnd_d [DEPTH];
    op_e           oper_q [DEPTH];
    op_e           oper_d [DEPTH];
    op_e           pend_q, pend_d;     // operator waiting for the reduce loop
    logic          expect_q, expect_d; // next token must be an operand
    logic          err_q, err_d;       // current expression is already known bad
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic [DW-1:0] result_q, result_d;

    // Stack tops; only meaningful when the matching pointer is large enough.
    logic [IW-1:0] o_top, o_nxt, o_push, p_top, p_push;
    logic [DW-1:0] opnd_a, opnd_b, red_val;
    op_e           top_op;
    logic          take, is_dig, osp_full, psp_full, can_reduce, red_cond;
    logic          fail, fin, fin_err;
    logic [3:0]    dig_val;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        osp_d    = osp_q;
        psp_d    = psp_q;
        opnd_d   = opnd_q;
        oper_d   = oper_q;
        pend_d   = pend_q;
        expect_d = expect_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        error_d  = error_q;
        result_d = result_q;
        fail     = 1'b0;
        fin      = 1'b0;
        fin_err  = 1'b0;
        red_cond = 1'b0;

        accept = (state_q == S_IDLE) || (state_q == S_READ) || (state_q == S_ERR);
        take   = ready && accept;

        o_top  = IW'(osp_q - PW'(1));
        o_nxt  = IW'(osp_q - PW'(2));
        o_push = IW'(osp_q);
        p_top  = IW'(psp_q - PW'(1));
        p_push = IW'(psp_q);
        opnd_a = opnd_q[o_nxt];
        opnd_b = opnd_q[o_top];
        top_op = oper_q[p_top];

        osp_full   = (osp_q == PW'(DEPTH));
        psp_full   = (psp_q == PW'(DEPTH));
        can_reduce = (osp_q >= PW'(2));

        case (top_op)
            OP_ADD:  red_val = opnd_a + opnd_b;
            OP_SUB:  red_val = opnd_a - opnd_b;
            OP_MUL:  red_val = opnd_a * opnd_b;
            default: red_val = '0;
        endcase

        is_dig = ((ascii_in >= "0") && (ascii_in <= "9")) ||
                 ((HEX != 0) && (ascii_in >= "a") && (ascii_in <= "f"));
        // Low nibble of '0'-'9' is the value; 'a'-'f' have low nibble 1-6.
        dig_val = (ascii_in <= "9") ? ascii_in[3:0] : ascii_in[3:0] + 4'd9;

        case (state_q)
            S_IDLE, S_READ: begin
                if (take) begin
                    state_d = S_READ;
                    if (is_dig) begin
                        if (!expect_q || osp_full) begin
                            fail = 1'b1;
                        end else begin
                            opnd_d[o_push] = DW'(dig_val);
                            osp_d          = osp_q + PW'(1);
                            expect_d       = 1'b0;
                        end
                    end else begin
                        case (ascii_in)
                            "(": begin
                                if (!expect_q || psp_full) begin
                                    fail = 1'b1;
                                end else begin
                                    oper_d[p_push] = OP_LPAR;
                                    psp_d          = psp_q + PW'(1);
                                end
                            end
                            "+", "-", "*", ")": begin
                                if (expect_q) begin
                                    fail = 1'b1;
                                end else begin
                                    case (ascii_in)
                                        "+":     pend_d = OP_ADD;
                                        "-":     pend_d = OP_SUB;
                                        "*":     pend_d = OP_MUL;
                                        default: pend_d = OP_RPAR;
                                    endcase
                                    expect_d = (ascii_in != ")");
                                    state_d  = S_REDUCE;
                                end
                            end
                            "=": begin
                                // '=' is consumed either way; a dangling operator
                                // is reported once the flush stage sees err_q.
                                err_d   = expect_q;
                                state_d = S_FLUSH;
                            end
                            default: fail = 1'b1;
                        endcase
                    end
                end
            end

            S_REDUCE: begin
                if (pend_q == OP_RPAR) begin
                    if (psp_q == '0) begin
                        fail = 1'b1;
                    end else if (top_op == OP_LPAR) begin
                        psp_d   = psp_q - PW'(1);
                        state_d = S_READ;
                    end else begin
                        red_cond = 1'b1;
                    end
                end else begin
                    // Left associativity: equal precedence on the stack reduces first.
                    if (psp_q != '0) begin
                        red_cond = (pend_q == OP_MUL) ? (top_op == OP_MUL)
                                                      : (top_op != OP_LPAR);
                    end
                    if (!red_cond) begin
                        if (psp_full) begin
                            fail = 1'b1;
                        end else begin
                            oper_d[p_push] = pend_q;
                            psp_d          = psp_q + PW'(1);
                            state_d        = S_READ;
                        end
                    end
                end
                if (red_cond) begin
                    if (!can_reduce) begin
                        fail = 1'b1;
                    end else begin
                        opnd_d[o_nxt] = red_val;
                        osp_d         = osp_q - PW'(1);
                        psp_d         = psp_q - PW'(1);
                    end
                end
            end

            S_FLUSH: begin
                if (err_q) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (psp_q != '0) begin
                    if ((top_op == OP_LPAR) || !can_reduce) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        opnd_d[o_nxt] = red_val;
                        osp_d         = osp_q - PW'(1);
                        psp_d         = psp_q - PW'(1);
                    end
                end else begin
                    fin     = 1'b1;
                    fin_err = (osp_q != PW'(1));
                end
            end

            S_DONE: begin
                state_d  = S_IDLE;
                osp_d    = '0;
                psp_d    = '0;
                expect_d = 1'b1;
                err_d    = 1'b0;
            end

            S_ERR: begin
                if (take && (ascii_in == "=")) begin
                    state_d = S_FLUSH;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            state_d = S_ERR;
            err_d   = 1'b1;
        end
        if (fin) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            error_d  = fin_err;
            result_d = fin_err ? '0 : opnd_q[0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            osp_q    <= '0;
            psp_q    <= '0;
            pend_q   <= OP_ADD;
            expect_q <= 1'b1;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            osp_q    <= osp_d;
            psp_q    <= psp_d;
            pend_q   <= pend_d;
            expect_q <= expect_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    // NOTE: stack storage is not reset; entries above the pointers are never
    // read, so clearing the pointers is enough to empty the stacks.
    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
        oper_q <= oper_d;
    end

    assign valid  = valid_q;
    assign error  = error_q;
    assign result = result_q;

endmodule

// File: tb/tb_aec_stream.sv
// -----------------------------------------------------------------------------
// tb_aec_stream
// Self-checking bench for aec_stream. Three instances share clock, reset and
// character bus: default parameters, HEX=0, and DEPTH=4. Each has its own
// ready strobe so only the selected instance consumes characters.
// Expected values come from a grammar-based evaluator (sum of products with a
// frame per parenthesis level) kept in this file.
// -----------------------------------------------------------------------------
module tb_aec_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ready;
    logic [7:0] ascii_in;
    logic [2:0] accept;
    logic [2:0] valid;
    logic [2:0] error;
    logic [7:0] result [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aec_stream #(.DW(8), .DEPTH(8), .HEX(1)) u_dut (
        .clk(clk), .rst(rst), .ready(ready[0]), .ascii_in(ascii_in),
        .accept(accept[0]), .valid(valid[0]), .result(result[0]), .error(error[0])
    );

    aec_stream #(.DW(8), .DEPTH(8), .HEX(0)) u_nohex (
        .clk(clk), .rst(rst), .ready(ready[1]), .ascii_in(ascii_in),
        .accept(accept[1]), .valid(valid[1]), .result(result[1]), .error(error[1])
    );

    aec_stream #(.DW(8), .DEPTH(4), .HEX(1)) u_d4 (
        .clk(clk), .rst(rst), .ready(ready[2]), .ascii_in(ascii_in),
        .accept(accept[2]), .valid(valid[2]), .result(result[2]), .error(error[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one character to instance s and return at the negedge after it is consumed.
    task automatic send(input int s, input byte ch, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        ascii_in  = ch;
        ready[s]  = 1'b1;
        n = 0;
        while (accept[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_wait[%0d]", s), 32'(accept[s]), 1);
        @(negedge clk);
        ready[s] = 1'b0;
    endtask

    // Send a full expression, then check the result pulse. exp_lat < 0 skips the
    // latency check; latency counts edges from the one that consumed '='.
    task automatic run_expr(input int s, input string str, input bit gaps,
                            input bit exp_err, input logic [7:0] exp_res, input int exp_lat);
        int k;
        for (int i = 0; i < str.len(); i++) send(s, str[i], gaps);
        check({str, " accept_after_eq"}, 32'(accept[s]), 0);
        k = 0;
        while (valid[s] !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({str, " valid"}, 32'(valid[s]), 1);
        if (exp_lat >= 0) check({str, " latency"}, k, exp_lat);
        check({str, " error"}, 32'(error[s]), 32'(exp_err));
        check({str, " result"}, 32'(result[s]), 32'(exp_res));
        check({str, " accept_done"}, 32'(accept[s]), 0);
        @(negedge clk);
        check({str, " valid_width"}, 32'(valid[s]), 0);
    endtask

    function automatic logic [7:0] digit_val(input byte c);
        if (c <= "9") return 8'(c - "0");
        return 8'(c - "a" + 10);
    endfunction

    // Reference evaluator: expr = sum of terms, term = product of factors.
    // Each parenthesis level keeps its running sum, pending add/sub and product.
    function automatic logic [7:0] model(input string e);
        logic [7:0] sum  [3];
        logic [7:0] prod [3];
        bit         sub  [3];
        logic [7:0] v;
        int         d = 0;
        byte        c;
        sum[0] = 0; prod[0] = 1; sub[0] = 0;
        for (int i = 0; i < e.len(); i++) begin
            c = e[i];
            if ((c >= "0" && c <= "9") || (c >= "a" && c <= "f")) begin
                prod[d] = prod[d] * digit_val(c);
            end else if (c == "(") begin
                d++;
                sum[d] = 0; prod[d] = 1; sub[d] = 0;
            end else if (c == ")") begin
                v = sub[d] ? sum[d] - prod[d] : sum[d] + prod[d];
                d--;
                prod[d] = prod[d] * v;
            end else if (c == "+" || c == "-") begin
                sum[d]  = sub[d] ? sum[d] - prod[d] : sum[d] + prod[d];
                prod[d] = 1;
                sub[d]  = (c == "-");
            end else if (c == "=") begin
                return sub[0] ? sum[0] - prod[0] : sum[0] + prod[0];
            end
        end
        return 8'hxx;
    endfunction

    // Random well-formed expression, nesting at most 2 so the DEPTH=8 stacks
    // never fill.
    function automatic string gen();
        string s      = "";
        string hexd   = "0123456789abcdef";
        string ops    = "+-*";
        int    d      = 0;
        int    len    = 0;
        int    budget = $urandom_range(3, 14);
        bit    expect_op = 1'b1;
        int    r;
        forever begin
            if (expect_op) begin
                if (d < 2 && len < budget && $urandom_range(0, 3) == 0) begin
                    s = {s, "("};
                    d++;
                end else begin
                    r = $urandom_range(0, 15);
                    s = {s, $sformatf("%c", hexd[r])};
                    expect_op = 1'b0;
                end
            end else if (len >= budget) begin
                if (d == 0) break;
                s = {s, ")"};
                d--;
            end else begin
                r = $urandom_range(0, 4);
                if (r <= 2) begin
                    s = {s, $sformatf("%c", ops[r])};
                    expect_op = 1'b1;
                end else if (r == 3 && d > 0) begin
                    s = {s, ")"};
                    d--;
                end else if (d == 0 && len > 2) begin
                    break;
                end else begin
                    s = {s, "*"};
                    expect_op = 1'b1;
                end
            end
            len++;
        end
        return {s, "="};
    endfunction

    initial begin
        string e;
        rst      = 1'b1;
        ready    = '0;
        ascii_in = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset valid[%0d]", s), 32'(valid[s]), 0);
            check($sformatf("reset accept[%0d]", s), 32'(accept[s]), 1);
            check($sformatf("reset error[%0d]", s), 32'(error[s]), 0);
            check($sformatf("reset result[%0d]", s), 32'(result[s]), 0);
        end
        rst = 1'b0;

        // Precedence, parentheses, wrap and hex operands.
        run_expr(0, "3+4*5=",       0, 0, 8'd23,  3);
        run_expr(0, "(2+3)*(4-1)=", 0, 0, 8'd15,  2);
        run_expr(0, "2-5=",         0, 0, 8'd253, 2);
        run_expr(0, "f*f*2=",       0, 0, 8'd194, 2);
        run_expr(0, "7=",           0, 0, 8'd7,   1);

        // Hex digits are illegal with HEX=0.
        run_expr(1, "f*f*2=", 0, 1, 8'd0, 1);
        run_expr(1, "9-4=",   0, 0, 8'd5, 2);

        // Operator stack overflow on the fifth '(' with DEPTH=4, then recovery.
        run_expr(2, "(((((1)))))=", 0, 1, 8'd0, 1);
        run_expr(2, "1+1=",         0, 0, 8'd2, 2);
        run_expr(2, "((((1))))=",   0, 0, 8'd1, 1);

        // Malformed expressions, each followed by a clean one.
        run_expr(0, "(1+2=", 0, 1, 8'd0, -1);
        run_expr(0, "7=",    0, 0, 8'd7, 1);
        run_expr(0, "1+)=",  0, 1, 8'd0, 1);
        run_expr(0, "7=",    0, 0, 8'd7, 1);
        run_expr(0, "12=",   0, 1, 8'd0, 1);
        run_expr(0, "7=",    0, 0, 8'd7, 1);
        run_expr(0, "1+=",   0, 1, 8'd0, 1);
        run_expr(0, "2+g=",  0, 1, 8'd0, 1);
        run_expr(0, "=",     0, 1, 8'd0, 1);
        run_expr(0, "7=",    0, 0, 8'd7, 1);

        // Reset midway through an expression discards it.
        e = "9*(8+";
        for (int i = 0; i < e.len(); i++) send(0, e[i], 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset accept", 32'(accept[0]), 1);
        check("midreset valid",  32'(valid[0]),  0);
        run_expr(0, "6-2*3=", 0, 0, 8'd0, 3);
        run_expr(0, "6-2*3=", 1, 0, 8'd0, 3);
        run_expr(0, "(9-2)*(3+4)-1=", 1, 0, 8'd48, -1);

        // Random well-formed expressions against the reference evaluator,
        // half of them with ready dropped randomly between characters.
        repeat (60) begin
            e = gen();
            run_expr(0, e, 1'($urandom_range(0, 1)), 0, model(e), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
